approx_mult_scheduler: RTL



---
 rtl/approx_mult_scheduler.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/approx_mult_scheduler.sv
// -----------------------------------------------------------------------------
// approx_mult_scheduler
//
// Shares one external, combinational approximate 8x8 multiplier between two
// requesters. A round-robin arbiter accepts one request at a time in IDLE.
// The winner's operands and accuracy level are latched. The level is turned
// into the multiplier's four truncation controls. The product is captured
// after EXEC_CYCLES settle cycles and returned on a valid/ready response
// channel, tagged with the requester ID and level.
//
// Optional build macro: APPROX_ERR_MON_EN
//   When defined, the block adds the rsp_err and err_acc outputs. rsp_err is
//   |exact - approximate| for each result. err_acc is a saturating sum of
//   rsp_err over the completed responses.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req0_* / req1_*          request channels: valid, ready (combinational),
//                            operands a/b [7:0], accuracy level [1:0]
//   mul_a, mul_b, mul_trunc  registered drive to the shared multiplier
//   mul_product              multiplier result, combinational from mul_*
//   rsp_valid, rsp_ready     response handshake
//   rsp_product, rsp_id,     captured 16-bit product, requester ID and level
//   rsp_lvl
//   rsp_err, err_acc         (APPROX_ERR_MON_EN only) error monitor outputs
// -----------------------------------------------------------------------------
module approx_mult_scheduler #(
    parameter logic [3:0]  LVL1_MASK   = 4'b0001,
    parameter logic [3:0]  LVL2_MASK   = 4'b0011,
    parameter logic [3:0]  LVL3_MASK   = 4'b0111,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [1:0]  req0_lvl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [1:0]  req1_lvl,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic [3:0]  mul_trunc,
    input  logic [15:0] mul_product,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_product,
    output logic        rsp_id,
    output logic [1:0]  rsp_lvl
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [15:0] rsp_err,
    output logic [23:0] err_acc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter runs EXEC_CYCLES-1 .. 0, so EXEC lasts EXEC_CYCLES cycles (1..4).
    localparam logic [1:0] CNT_LOAD = 2'(EXEC_CYCLES - 1);

    // Translate an accuracy level into the truncation controls.
    function automatic logic [3:0] lvl_to_mask(input logic [1:0] lvl);
        logic [3:0] mask;
        case (lvl)
            2'd0:    mask = 4'b0000;
            2'd1:    mask = LVL1_MASK;
            2'd2:    mask = LVL2_MASK;
            2'd3:    mask = LVL3_MASK;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_last_grant;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;
    logic [3:0]  r_mul_trunc;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_product;
    logic        r_rsp_id;
    logic [1:0]  r_rsp_lvl;

    logic        w_grant_valid;
    logic        w_grant_id;
    logic [7:0]  w_win_a;
    logic [7:0]  w_win_b;
    logic [1:0]  w_win_lvl;

    // Round-robin arbitration: grant only in IDLE. On a tie the requester
    // that was not granted last wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end else begin
                w_grant_valid = 1'b0;
                w_grant_id    = 1'b0;
            end
        end else begin
            w_grant_valid = 1'b0;
            w_grant_id    = 1'b0;
        end
    end

    // Select the winner's payload for latching.
    always_comb begin
        w_win_a   = req0_a;
        w_win_b   = req0_b;
        w_win_lvl = req0_lvl;
        if (w_grant_id) begin
            w_win_a   = req1_a;
            w_win_b   = req1_b;
            w_win_lvl = req1_lvl;
        end else begin
            w_win_a   = req0_a;
            w_win_b   = req0_b;
            w_win_lvl = req0_lvl;
        end
    end

    assign req0_ready = w_grant_valid & ~w_grant_id;
    assign req1_ready = w_grant_valid &  w_grant_id;

`ifdef APPROX_ERR_MON_EN
    // Absolute difference between the exact and the approximate product.
    function automatic logic [15:0] abs_diff(input logic [15:0] exact,
                                             input logic [15:0] approx);
        logic [15:0] diff;
        if (exact >= approx) begin
            diff = exact - approx;
        end else begin
            diff = approx - exact;
        end
        return diff;
    endfunction

    // Accumulate with saturation at the 24-bit maximum.
    function automatic logic [23:0] sat_add(input logic [23:0] acc,
                                            input logic [15:0] inc);
        logic [24:0] sum;
        logic [23:0] res;
        sum = {1'b0, acc} + {9'd0, inc};
        if (sum[24]) begin
            res = 24'hFF_FFFF;
        end else begin
            res = sum[23:0];
        end
        return res;
    endfunction

    logic [15:0] r_rsp_err;
    logic [23:0] r_err_acc;
    logic [15:0] w_exact;

    assign w_exact = 16'(r_mul_a) * 16'(r_mul_b);
`endif

    // Main FSM: arbitration acceptance, settle counting, capture and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 2'd0;
            r_last_grant  <= 1'b1;
            r_mul_a       <= 8'd0;
            r_mul_b       <= 8'd0;
            r_mul_trunc   <= 4'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_product <= 16'd0;
            r_rsp_id      <= 1'b0;
            r_rsp_lvl     <= 2'd0;
`ifdef APPROX_ERR_MON_EN
            r_rsp_err     <= 16'd0;
            r_err_acc     <= 24'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_mul_a      <= w_win_a;
                        r_mul_b      <= w_win_b;
                        r_mul_trunc  <= lvl_to_mask(w_win_lvl);
                        r_rsp_id     <= w_grant_id;
                        r_rsp_lvl    <= w_win_lvl;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= ST_EXEC;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt         <= r_cnt - 2'd1;
                    end else begin
                        r_rsp_product <= mul_product;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RESP;
`ifdef APPROX_ERR_MON_EN
                        r_rsp_err     <= abs_diff(w_exact, mul_product);
`endif
                    end
                end
                ST_RESP: begin
                    // r_rsp_valid is always set in RESP, so rsp_ready alone
                    // completes the handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
`ifdef APPROX_ERR_MON_EN
                        r_err_acc   <= sat_add(r_err_acc, r_rsp_err);
`endif
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_trunc   = r_mul_trunc;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign rsp_id      = r_rsp_id;
    assign rsp_lvl     = r_rsp_lvl;
`ifdef APPROX_ERR_MON_EN
    assign rsp_err     = r_rsp_err;
    assign err_acc     = r_err_acc;
`endif

endmodule
